// File: rtl/aes_prng_reseed_ctrl.sv
// -----------------------------------------------------------------------------
// aes_prng_reseed_ctrl
//
// Reseed scheduler and entropy prefetch buffer for the AES clearing PRNG.
//
// Scheduler:
//   Counts completed cipher blocks while idle and raises a reseed request to
//   the PRNG when the count reaches the selected threshold, or when software
//   pulses the trigger. The request is held until the PRNG acknowledges, and
//   then the block counter starts again from zero.
//
// Prefetch buffer:
//   A 2-entry FIFO that stays filled from EDN so that a PRNG reseed can draw
//   entropy words without waiting on a full EDN round trip. Words reach the
//   PRNG only while a reseed is in progress.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   block_done_i     one-cycle pulse per completed AES block
//   reseed_rate_i    00: every block, 01: every 64, 10: every 8192, 11: off
//   reseed_trigger_i software reseed pulse
//   busy_o           reseed in progress
//   reseed_req_o     reseed request to the PRNG (held until reseed_ack_i)
//   reseed_ack_i     reseed acknowledge from the PRNG
//   entropy_req_i    entropy word request from the PRNG
//   entropy_ack_o    entropy word acknowledge to the PRNG (combinational)
//   entropy_o        entropy word to the PRNG (FIFO head, 0 when empty)
//   edn_req_o        request to EDN (held until an accepted ack)
//   edn_ack_i        EDN acknowledge, edn_data_i valid
//   edn_data_i       EDN data word
// -----------------------------------------------------------------------------
module aes_prng_reseed_ctrl #(
  parameter int EntropyWidth = 32,
  // The buffer is fixed at 2 entries; pointer wrap below relies on a
  // power-of-two depth.
  parameter int FifoDepth    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    block_done_i,
  input  logic [1:0]              reseed_rate_i,
  input  logic                    reseed_trigger_i,
  output logic                    busy_o,
  output logic                    reseed_req_o,
  input  logic                    reseed_ack_i,
  input  logic                    entropy_req_i,
  output logic                    entropy_ack_o,
  output logic [EntropyWidth-1:0] entropy_o,
  output logic                    edn_req_o,
  input  logic                    edn_ack_i,
  input  logic [EntropyWidth-1:0] edn_data_i
);

  // ---------------------------------------------------------------------------
  // Local parameters and types
  // ---------------------------------------------------------------------------
  localparam int BlkCntW = 13;
  // One extra bit so that counter+1 can equal 8192 without wrapping.
  localparam int ThrW    = BlkCntW + 1;
  localparam int PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int FCntW   = $clog2(FifoDepth + 1);

  localparam logic [FCntW-1:0] FifoFull = FCntW'(FifoDepth);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESEED = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Scheduler signals
  // ---------------------------------------------------------------------------
  state_e               r_state;
  state_e               w_state_nxt;
  logic [BlkCntW-1:0]   r_blk_cnt;
  logic [BlkCntW-1:0]   w_blk_cnt_nxt;
  logic [ThrW-1:0]      w_thresh;
  logic [ThrW-1:0]      w_blk_cnt_inc;
  logic                 w_auto_en;
  logic                 w_auto_fire;
  logic                 w_busy;

  // ---------------------------------------------------------------------------
  // Threshold decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_thresh  = '0;
    w_auto_en = 1'b1;
    unique case (reseed_rate_i)
      2'b00:   w_thresh = ThrW'(1);
      2'b01:   w_thresh = ThrW'(64);
      2'b10:   w_thresh = ThrW'(8192);
      default: w_auto_en = 1'b0;
    endcase
  end

  assign w_blk_cnt_inc = {1'b0, r_blk_cnt} + ThrW'(1);

  // Equality (not >=) is deliberate: after a rate change that leaves the
  // counter already at or past the new threshold, no auto-fire happens until
  // the counter wraps round to it again.
  assign w_auto_fire = (r_state == ST_IDLE) & block_done_i & w_auto_en &
                       (w_blk_cnt_inc == w_thresh);

  // ---------------------------------------------------------------------------
  // Scheduler FSM: next state, counter and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_blk_cnt_nxt = r_blk_cnt;
    w_busy        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // The counter advances on every block in IDLE, including the one
        // that fires; the counter wraps modulo 2^13 when auto-reseed is off.
        if (block_done_i) begin
          w_blk_cnt_nxt = w_blk_cnt_inc[BlkCntW-1:0];
        end
        // Trigger and auto-fire in the same cycle collapse into one reseed.
        if (w_auto_fire || reseed_trigger_i) begin
          w_state_nxt = ST_RESEED;
        end
      end

      ST_RESEED: begin
        // Blocks are not counted here and a trigger merges into the reseed
        // already in flight, so neither input is looked at in this state.
        w_busy = 1'b1;
        if (reseed_ack_i) begin
          w_state_nxt   = ST_IDLE;
          w_blk_cnt_nxt = '0;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_blk_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_blk_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_blk_cnt <= w_blk_cnt_nxt;
    end
  end

  assign busy_o       = w_busy;
  assign reseed_req_o = w_busy;

  // ---------------------------------------------------------------------------
  // Entropy prefetch FIFO
  // ---------------------------------------------------------------------------
  logic [EntropyWidth-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]         r_wr_ptr;
  logic [PtrW-1:0]         r_rd_ptr;
  logic [FCntW-1:0]        r_count;
  logic                    w_not_empty;
  logic                    w_edn_req;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_entropy_ack;

  assign w_not_empty = (r_count != '0);

  // Gating with rst_i abandons any outstanding EDN request during reset and
  // makes an edn_ack_i arriving in that window a no-op. Outside reset, the
  // request can only drop through a push that fills the buffer, so it is
  // never withdrawn before EDN acknowledges.
  assign w_edn_req = (r_count < FifoFull) & ~rst_i;

  // An ack while the request is low (buffer full or in reset) is ignored.
  assign w_push = w_edn_req & edn_ack_i;

  // Words are only served during a reseed; an empty buffer stalls the PRNG.
  assign w_entropy_ack = entropy_req_i & w_busy & w_not_empty;
  assign w_pop         = entropy_req_i & w_entropy_ack;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      // Push and pop together leave the occupancy unchanged; the separate
      // pointers keep arrival order.
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCntW'(1);
        2'b01:   r_count <= r_count - FCntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are never observed
  // unless r_count says the entry is valid, and reset clears r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= edn_data_i;
    end
  end

  // Registered storage means a pushed word reaches the head at the earliest
  // in the cycle after its edn_ack_i.
  assign entropy_o     = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign entropy_ack_o = w_entropy_ack;
  assign edn_req_o     = w_edn_req;

endmodule

// File: tb/tb_aes_prng_reseed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_prng_reseed_ctrl
//
// Self-checking bench for aes_prng_reseed_ctrl. A table of per-cycle vectors
// covers reset, buffer fill and a reseed drain; hand-written sequences cover
// the multi-cycle corner cases. Every EDN word the bench expects to be
// accepted is queued, and each entropy handshake from the DUT pops the queue
// and compares the delivered word.
// -----------------------------------------------------------------------------
module tb_aes_prng_reseed_ctrl;

  localparam int W = 32;

  localparam logic [W-1:0] WA = 32'h1111_1111;
  localparam logic [W-1:0] WB = 32'h2222_2222;
  localparam logic [W-1:0] WC = 32'hC0FF_EE00;
  localparam logic [W-1:0] WD = 32'hDDDD_0001;
  localparam logic [W-1:0] WE = 32'hEEEE_0002;
  localparam logic [W-1:0] WF = 32'hF00D_0003;
  localparam logic [W-1:0] WX = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         block_done_i = 1'b0;
  logic [1:0]   reseed_rate_i = 2'b11;
  logic         reseed_trigger_i = 1'b0;
  logic         busy_o;
  logic         reseed_req_o;
  logic         reseed_ack_i = 1'b0;
  logic         entropy_req_i = 1'b0;
  logic         entropy_ack_o;
  logic [W-1:0] entropy_o;
  logic         edn_req_o;
  logic         edn_ack_i = 1'b0;
  logic [W-1:0] edn_data_i = '0;

  always #5 clk = ~clk;

  aes_prng_reseed_ctrl #(
    .EntropyWidth (W),
    .FifoDepth    (2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .block_done_i     (block_done_i),
    .reseed_rate_i    (reseed_rate_i),
    .reseed_trigger_i (reseed_trigger_i),
    .busy_o           (busy_o),
    .reseed_req_o     (reseed_req_o),
    .reseed_ack_i     (reseed_ack_i),
    .entropy_req_i    (entropy_req_i),
    .entropy_ack_o    (entropy_ack_o),
    .entropy_o        (entropy_o),
    .edn_req_o        (edn_req_o),
    .edn_ack_i        (edn_ack_i),
    .edn_data_i       (edn_data_i)
  );

  // ---------------------------------------------------------------------------
  // Stimulus / vector types
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic         rst;
    logic         bd;
    logic         trig;
    logic         rack;
    logic         ereq;
    logic         eack;
    logic [W-1:0] data;
  } stim_t;

  typedef struct packed {
    stim_t        s;
    logic         busy;
    logic         ent_ack;
    logic         edn_req;
    logic [W-1:0] ent;
  } vec_t;

  function automatic stim_t st(input logic rst, input logic bd, input logic trig,
                               input logic rack, input logic ereq, input logic eack,
                               input logic [W-1:0] data);
    stim_t r;
    r.rst = rst; r.bd = bd; r.trig = trig; r.rack = rack;
    r.ereq = ereq; r.eack = eack; r.data = data;
    return r;
  endfunction

  function automatic vec_t vc(input stim_t s, input logic busy, input logic ent_ack,
                              input logic edn_req, input logic [W-1:0] ent);
    vec_t r;
    r.s = s; r.busy = busy; r.ent_ack = ent_ack; r.edn_req = edn_req; r.ent = ent;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] sb_q[$];

  // Combinational outputs sampled inside the most recent driven cycle.
  logic         s_busy;
  logic         s_eack;
  logic         s_edn_req;
  logic [W-1:0] s_ent;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, sample combinational outputs mid-cycle,
  // run the scoreboard, then advance past the rising edge.
  task automatic drive(input stim_t s);
    logic         exp_req;
    logic         accept;
    logic [W-1:0] exp_word;
    rst_i            = s.rst;
    block_done_i     = s.bd;
    reseed_trigger_i = s.trig;
    reseed_ack_i     = s.rack;
    entropy_req_i    = s.ereq;
    edn_ack_i        = s.eack;
    edn_data_i       = s.data;
    #1;
    s_busy    = busy_o;
    s_eack    = entropy_ack_o;
    s_edn_req = edn_req_o;
    s_ent     = entropy_o;

    exp_req = !s.rst && (sb_q.size() < 2);
    accept  = s.eack && exp_req;
    check("edn_req", W'(edn_req_o), W'(exp_req));
    check("req_eq_busy", W'(reseed_req_o), W'(busy_o));

    if (s.ereq && entropy_ack_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got ack with word 0x%08h, expected no ack (buffer empty) (t=%0t)",
                 entropy_o, $time);
      end else begin
        exp_word = sb_q.pop_front();
        check("sb_word", entropy_o, exp_word);
      end
    end
    if (accept) sb_q.push_back(s.data);

    @(posedge clk);
    #1;
    if (s.rst) sb_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(st(0, 0, 0, 0, 0, 0, '0));
  endtask

  // n block_done pulses; returns whether busy was ever seen high afterwards.
  task automatic pulses(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(st(0, 1, 0, 0, 0, 0, '0));
      if (busy_o) seen = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  vec_t vecs[11];
  logic seen;

  initial begin
    //                  rst bd trg rak erq eak data        busy eack ereq ent
    vecs[0]  = vc(st(1, 0, 0, 0, 0, 0, '0), 0, 0, 0, '0);
    vecs[1]  = vc(st(1, 0, 0, 0, 1, 1, WX), 0, 0, 0, '0);  // ack in reset ignored
    vecs[2]  = vc(st(0, 0, 0, 0, 0, 1, WA), 0, 0, 1, '0);  // req up right after reset
    vecs[3]  = vc(st(0, 0, 0, 0, 1, 1, WB), 0, 0, 1, WA);  // IDLE: no entropy ack
    vecs[4]  = vc(st(0, 0, 0, 0, 1, 0, '0), 0, 0, 0, WA);  // full: req low
    vecs[5]  = vc(st(0, 0, 1, 0, 0, 0, '0), 0, 0, 0, WA);  // software trigger
    vecs[6]  = vc(st(0, 0, 0, 0, 1, 0, '0), 1, 1, 0, WA);  // pop A
    vecs[7]  = vc(st(0, 0, 0, 0, 1, 0, '0), 1, 1, 1, WB);  // pop B, req back up
    vecs[8]  = vc(st(0, 0, 0, 0, 1, 0, '0), 1, 0, 1, '0);  // empty: stall
    vecs[9]  = vc(st(0, 0, 0, 1, 0, 0, '0), 1, 0, 1, '0);  // PRNG acks reseed
    vecs[10] = vc(st(0, 0, 0, 0, 0, 0, '0), 0, 0, 1, '0);

    @(posedge clk);
    #1;
    check("reset_busy", W'(busy_o), '0);
    check("reset_ent", entropy_o, '0);

    foreach (vecs[i]) begin
      drive(vecs[i].s);
      check($sformatf("vec%0d_busy", i), W'(s_busy), W'(vecs[i].busy));
      check($sformatf("vec%0d_eack", i), W'(s_eack), W'(vecs[i].ent_ack));
      check($sformatf("vec%0d_ednreq", i), W'(s_edn_req), W'(vecs[i].edn_req));
      check($sformatf("vec%0d_ent", i), s_ent, vecs[i].ent);
    end

    // Auto-fire at rate 01: 63 blocks silent, 64th fires, counter restarts.
    reseed_rate_i = 2'b01;
    for (int round = 0; round < 2; round++) begin
      pulses(63, seen);
      check($sformatf("r01_no_early_%0d", round), W'(seen), '0);
      drive(st(0, 1, 0, 0, 0, 0, '0));
      check($sformatf("r01_fire_%0d", round), W'(busy_o), W'(1));
      drive(st(0, 1, 0, 1, 0, 0, '0));  // block ignored in RESEED, ack
      check($sformatf("r01_ack_%0d", round), W'(busy_o), '0);
    end

    // Rate change with counter already past the new threshold: no fire.
    pulses(10, seen);
    reseed_rate_i = 2'b00;
    drive(st(0, 1, 0, 0, 0, 0, '0));
    check("rate_change_nofire", W'(busy_o), '0);
    drive(st(0, 0, 1, 0, 0, 0, '0));
    drive(st(0, 0, 0, 1, 0, 0, '0));
    check("rate_change_clear", W'(busy_o), '0);
    // Rate 00: every block fires.
    drive(st(0, 1, 0, 0, 0, 0, '0));
    check("r00_fire", W'(busy_o), W'(1));
    drive(st(0, 0, 0, 1, 0, 0, '0));
    // Trigger together with an auto-fire: one reseed only.
    drive(st(0, 1, 1, 0, 0, 0, '0));
    check("both_fire", W'(busy_o), W'(1));
    drive(st(0, 0, 0, 1, 0, 0, '0));
    idle(3);
    check("both_single", W'(busy_o), '0);

    // Triggers during RESEED merge into the running reseed.
    reseed_rate_i = 2'b11;
    drive(st(0, 0, 1, 0, 0, 0, '0));
    drive(st(0, 0, 1, 0, 0, 0, '0));
    drive(st(0, 0, 1, 0, 0, 0, '0));
    check("merge_busy", W'(busy_o), W'(1));
    drive(st(0, 0, 0, 1, 0, 0, '0));
    check("merge_ack", W'(busy_o), '0);
    idle(3);
    check("merge_single", W'(busy_o), '0);
    // Trigger the cycle right after the ack starts a fresh reseed.
    drive(st(0, 0, 1, 0, 0, 0, '0));
    drive(st(0, 0, 0, 1, 0, 0, '0));
    check("back2back_ack", W'(busy_o), '0);
    drive(st(0, 0, 1, 0, 0, 0, '0));
    check("back2back_retrig", W'(busy_o), W'(1));
    drive(st(0, 0, 0, 1, 0, 0, '0));

    // Auto-reseed disabled: counter wraps, only the trigger reseeds.
    pulses(10000, seen);
    check("r11_no_reseed", W'(seen), '0);
    drive(st(0, 0, 1, 0, 0, 0, '0));
    check("r11_trigger", W'(busy_o), W'(1));
    drive(st(0, 0, 0, 1, 0, 0, '0));
    check("r11_ack", W'(busy_o), '0);

    // Empty buffer during reseed: PRNG stalls until EDN delivers C.
    drive(st(0, 0, 1, 0, 0, 0, '0));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(st(0, 0, 0, 0, 1, 0, '0));
      if (s_eack) seen = 1'b1;
    end
    check("empty_stall", W'(seen), '0);
    drive(st(0, 0, 0, 0, 1, 1, WC));
    check("empty_ack_cycle", W'(s_eack), '0);
    drive(st(0, 0, 0, 0, 1, 0, '0));
    check("empty_c_ack", W'(s_eack), W'(1));
    check("empty_c_word", s_ent, WC);
    drive(st(0, 0, 0, 1, 0, 0, '0));

    // Reset mid-reseed with one buffered word; ack during reset not stored.
    drive(st(0, 0, 0, 0, 0, 1, WD));
    drive(st(0, 0, 1, 0, 0, 0, '0));
    check("mid_rst_busy_pre", W'(busy_o), W'(1));
    drive(st(1, 0, 0, 0, 0, 0, '0));
    check("mid_rst_ednreq", W'(s_edn_req), '0);
    check("mid_rst_busy", W'(busy_o), '0);
    drive(st(1, 0, 0, 0, 1, 1, WE));
    check("mid_rst_eack", W'(s_eack), '0);
    check("mid_rst_ent", s_ent, '0);
    drive(st(0, 0, 0, 0, 0, 1, WF));
    check("post_rst_ednreq", W'(s_edn_req), W'(1));
    check("post_rst_empty", s_ent, '0);
    drive(st(0, 0, 1, 0, 0, 0, '0));
    drive(st(0, 0, 0, 0, 1, 0, '0));
    check("post_rst_ack", W'(s_eack), W'(1));
    check("post_rst_word", s_ent, WF);
    drive(st(0, 0, 0, 1, 0, 0, '0));
    idle(2);
    check("sb_drained", W'(sb_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
